mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencing controller that sits directly upstream of the 3-to-1 mux (`mux3to1`) and also consumes its output. It walks the mux select through channels 0, 1 and 2, waits a programmable settle time on each, and samples the 1-bit mux output. It then presents the three samples as one 3-bit frame on a valid/ready handshake. It never drives the undefined select code 2'b11.

## Interface
- `SETTLE_CYC`, default 2: cycles `sel` is held stable before each sample; legal range 1..15, held in a 4-bit counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one scan; sampled only in IDLE.
- `mux_out` in 1: output of the downstream mux.
- `out_ready` in 1: consumer accepts the frame.
- `sel` out 2: registered mux select; only 2'b00, 2'b01 or 2'b10 are ever driven.
- `out_valid` out 1: frame is available.
- `out_frame` out 3: bit i holds the sample taken with `sel`=i.
- `busy` out 1: high whenever state ≠ IDLE.
- `frame_cnt` out 8: count of accepted frames.

## Operation
- Reset values: state=IDLE, `sel`=2'b00, `out_valid`=0, `out_frame`=3'b000, `busy`=0, `frame_cnt`=0, internal channel index=0, settle counter=0, sample shadow=0.
- IDLE:
  - `sel`=00.
  - If `start`=1: go to SETTLE with channel=0 and counter=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter==`SETTLE_CYC`-1: go to SAMPLE.
- SAMPLE (1 cycle): shadow[channel] is loaded from `mux_out`.
  - If channel<2: channel+1, `sel`=channel+1, counter=0, go to SETTLE.
  - If channel==2: `out_frame` is loaded with {`mux_out`, shadow[1], shadow[0]}, `out_valid`=1, `sel`=00, go to DONE.
- DONE:
  - `out_valid` and `out_frame` hold until `out_valid`&&`out_ready`.
  - On that handshake cycle: `out_valid`←0, `frame_cnt`←`frame_cnt`+1 (wraps 255→0), next state per Configuration.
- `start` is ignored outside IDLE; there is no queuing.
- `out_ready` is ignored while `out_valid`=0.
- `out_frame` keeps its last value after the handshake until the next frame loads.
- Reset mid-scan: all state returns to the reset values on the next edge and partial samples are discarded. Reset has priority over `start` and the handshake.

## Timing
- `sel` is registered.
  - Each channel is presented for `SETTLE_CYC`+1 cycles: settle cycles plus the sample cycle.
  - `mux_out` is sampled in the last cycle the channel is presented, after `sel` has been stable for `SETTLE_CYC` cycles.
- Latency: with `start` high in cycle T, `out_valid` is first high in cycle T+3·(`SETTLE_CYC`+1)+1. With the default `SETTLE_CYC`=2 this is T+10.
- Handshake completes in the cycle where both signals are high. `out_valid` is low in the following cycle.
- Back-to-back throughput:
  - Macro off: one frame per 3·(`SETTLE_CYC`+1)+2 cycles, with `start` held high.
  - Macro on: one frame per 3·(`SETTLE_CYC`+1)+1 cycles.

## Configuration
- `MUX_SCAN_CONTINUOUS_EN`
  - Defined: after a handshake the FSM goes directly to SETTLE with channel=0 and `sel`=00. It scans continuously and never returns to IDLE unless reset. `busy` stays 1 after the first `start`.
  - Undefined: after a handshake the FSM returns to IDLE and waits for a new `start`.

## Test plan
- Basic scan: mux model inputs a=4'b0101, `SETTLE_CYC`=2, `start` pulse in cycle 5.
  - `sel`=00 for cycles 6–8, 01 for 9–11, 10 for 12–14.
  - `out_valid`=1 in cycle 15 with `out_frame`=3'b101.
  - `sel` never equals 11.
- Backpressure: hold `out_ready`=0 for 6 cycles after `out_valid`, with a changing to 4'b0010 during that time.
  - `out_frame` stays 3'b101, `out_valid` stays 1, `sel`=00.
  - Raising `out_ready` gives `frame_cnt`=1 and `out_valid`=0 on the next cycle.
- Start while busy: pulse `start` during channel-1 settle.
  - No effect: frame timing identical to basic scan, exactly one frame.
- Reset mid-scan: assert `rst` in the second SAMPLE cycle.
  - Next cycle: `sel`=00, `busy`=0, `out_valid`=0, `frame_cnt` unchanged from reset (0).
  - No frame emitted.
- Counter wrap: complete 256 frames with `out_ready`=1.
  - `frame_cnt` reads 255 after frame 255 and 0 after frame 256.
- Continuous mode, macro defined: single `start`, `out_ready`=1.
  - Frames every 10 cycles (`SETTLE_CYC`=2) with no further `start`.
  - Undefined build: only one frame is produced.

Source files
------------

// File: rtl/mux_scan_if.sv
// mux_scan_if: signal bundle between the scan controller and its environment.
// The controller side (master) drives the mux select, the sampled frame and
// status; the environment side (slave) drives start, the mux output and the
// frame consumer's ready.
interface mux_scan_if;
    logic       start;
    logic       mux_out;
    logic       out_ready;
    logic [1:0] sel;
    logic       out_valid;
    logic [2:0] out_frame;
    logic       busy;
    logic [7:0] frame_cnt;

    modport master (
        input  start, mux_out, out_ready,
        output sel, out_valid, out_frame, busy, frame_cnt
    );

    modport slave (
        output start, mux_out, out_ready,
        input  sel, out_valid, out_frame, busy, frame_cnt
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 3-to-1 mux select through channels 0, 1, 2, lets
// each channel settle for SETTLE_CYC cycles, samples the mux output, and
// offers the three samples as one 3-bit frame on a valid/ready handshake.
// The select code 2'b11 is never driven.
// Optional feature: define MUX_SCAN_CONTINUOUS_EN to restart a new scan
// straight after each accepted frame instead of returning to IDLE.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 2    // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    mux_scan_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ch_q, ch_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] shadow_q, shadow_d;     // samples of channels 0 and 1
    logic [2:0] frame_q, frame_d;
    logic       valid_q, valid_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       handshake;

    assign handshake = valid_q && bus.out_ready;

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of the others, matching real flip-flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            sel_q       <= '0;
            shadow_q    <= '0;
            frame_q     <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            frame_q     <= frame_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic of the scan sequencer.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE:  if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (ch_q == 2'd2) ? DONE : SETTLE;
            DONE: begin
                if (handshake) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
                    state_d = SETTLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of counter, channel, select, samples, frame and frame count.
    always_comb begin
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        frame_d     = frame_q;
        valid_d     = valid_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                sel_d = 2'd0;
                if (bus.start) begin
                    ch_d  = 2'd0;
                    cnt_d = 4'd0;
                end
            end
            SETTLE: cnt_d = cnt_q + 4'd1;
            SAMPLE: begin
                if (ch_q != 2'd2) begin
                    // Channels 0 and 1 only reach this branch, so bit 0 of
                    // the channel index selects the shadow bit.
                    shadow_d[ch_q[0]] = bus.mux_out;
                    ch_d              = ch_q + 2'd1;
                    sel_d             = ch_q + 2'd1;
                    cnt_d             = 4'd0;
                end else begin
                    frame_d = {bus.mux_out, shadow_q};
                    valid_d = 1'b1;
                    sel_d   = 2'd0;
                end
            end
            DONE: begin
                if (handshake) begin
                    valid_d     = 1'b0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
`ifdef MUX_SCAN_CONTINUOUS_EN
                    ch_d        = 2'd0;
                    cnt_d       = 4'd0;
                    sel_d       = 2'd0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs come straight from registers; busy decodes the state.
    always_comb begin
        bus.sel       = sel_q;
        bus.out_valid = valid_q;
        bus.out_frame = frame_q;
        bus.frame_cnt = frame_cnt_q;
        bus.busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: self-checking bench for mux_scan_ctrl. A 3-to-1 mux model
// feeds the controller; a timing-level reference model (scan offset, sample
// points, handshake) predicts every output each cycle.
// Honours MUX_SCAN_CONTINUOUS_EN when compiled with it.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

    localparam int SETTLE = 2;
    localparam int P      = SETTLE + 1;      // cycles each channel is shown
`ifdef MUX_SCAN_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;                           // mux data inputs, a[3] = undefined leg
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         chk_en = 1'b0;

    mux_scan_if bus ();

    mux_scan_ctrl #(.SETTLE_CYC(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mux_out = a[bus.sel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: m_off counts cycles since the scan began (-1 = not
    // scanning); channel = m_off / P, a sample is taken at its last cycle.
    int         m_off;
    logic       m_valid;
    logic [2:0] m_frame;
    logic [1:0] m_shadow;
    logic [7:0] m_cnt;

    always @(posedge clk) begin
        int         n_off;
        logic       n_valid;
        logic [2:0] n_frame;
        logic [1:0] n_shadow;
        logic [7:0] n_cnt;
        n_off    = m_off;
        n_valid  = m_valid;
        n_frame  = m_frame;
        n_shadow = m_shadow;
        n_cnt    = m_cnt;
        if (rst) begin
            n_off = -1; n_valid = 1'b0; n_frame = '0; n_shadow = '0; n_cnt = '0;
        end else if (m_valid) begin
            if (bus.out_ready) begin
                n_valid = 1'b0;
                n_cnt   = m_cnt + 8'd1;
                n_off   = CONT ? 0 : -1;
            end
        end else if (m_off < 0) begin
            if (bus.start) n_off = 0;
        end else if (m_off % P == P - 1) begin
            if (m_off / P == 2) begin
                n_frame = {a[2], m_shadow};
                n_valid = 1'b1;
                n_off   = -1;
            end else begin
                n_shadow[m_off / P] = a[m_off / P];
                n_off = m_off + 1;
            end
        end else begin
            n_off = m_off + 1;
        end
        m_off    <= n_off;
        m_valid  <= n_valid;
        m_frame  <= n_frame;
        m_shadow <= n_shadow;
        m_cnt    <= n_cnt;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("sel",       bus.sel,       (m_off >= 0) ? m_off / P : 0);
            check("sel_legal", bus.sel != 2'b11, 1);
            check("out_valid", bus.out_valid, m_valid);
            check("out_frame", bus.out_frame, m_frame);
            check("busy",      bus.busy,      (m_off >= 0) || m_valid);
            check("frame_cnt", bus.frame_cnt, m_cnt);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.start = 1'b0; bus.out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (bus.out_valid) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) check("valid_timeout", bus.out_valid, 1);
    endtask

    initial begin
        int t0, tv, tv2, gap, k;
        rst = 1'b1; bus.start = 1'b0; bus.out_ready = 1'b0; a = 4'b0101;
        tick(2);
        chk_en = 1'b1;
        check("rst_sel",   bus.sel,       0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_frame", bus.out_frame, 0);
        check("rst_busy",  bus.busy,      0);
        check("rst_cnt",   bus.frame_cnt, 0);
        rst = 1'b0;
        tick(2);

        // Basic scan with a = 0101, then backpressure while a changes.
        bus.start = 1'b1; t0 = cyc; tick(); bus.start = 1'b0;
        wait_valid(40, tv);
        check("basic_latency", tv - t0, 3 * P + 1);
        check("basic_frame",   bus.out_frame, 3'b101);
        a = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            check("bp_frame", bus.out_frame, 3'b101);
            check("bp_valid", bus.out_valid, 1);
            check("bp_sel",   bus.sel,       0);
            tick();
        end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        check("bp_cnt",       bus.frame_cnt, 1);
        check("bp_valid_low", bus.out_valid, 0);
        do_reset();

        // Start pulse while busy during channel-1 settle must be ignored.
        a = 4'($urandom); bus.out_ready = 1'b1;
        bus.start = 1'b1; t0 = cyc; tick(); bus.start = 1'b0;
        tick(3);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_valid(40, tv);
        check("busy_latency", tv - t0, 3 * P + 1);
        check("busy_frame",   bus.out_frame, a[2:0]);
        tick(25);
        check("busy_frames",  bus.frame_cnt, CONT ? 3 : 1);
        do_reset();

        // Reset asserted in the second SAMPLE cycle discards the scan.
        a = 4'($urandom);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(5);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_sel",   bus.sel,       0);
        check("mrst_busy",  bus.busy,      0);
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_cnt",   bus.frame_cnt, 0);
        tick(15);
        check("mrst_noframe", bus.frame_cnt, 0);
        check("mrst_frame",   bus.out_frame, 0);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.out_ready = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) a = 4'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        do_reset();

        // Frame counter wrap over 256 accepted frames.
        bus.out_ready = 1'b1; bus.start = 1'b1; k = 0;
        for (int i = 0; i < 256 * (3 * P + 2) + 50 && k < 256; i++) begin
            if (bus.out_valid) begin
                k++;
                tick();
                if (k == 255) check("wrap_255", bus.frame_cnt, 255);
                if (k == 256) check("wrap_0",   bus.frame_cnt, 0);
            end else begin
                tick();
            end
        end
        check("wrap_frames", k, 256);
        bus.start = 1'b0;
        do_reset();

        // Single start with ready high: continuous build repeats every
        // 3*P+1 cycles, default build stops after one frame.
        bus.out_ready = 1'b1; a = 4'($urandom);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_valid(40, tv);
        tick();
        tv2 = -1;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) begin
                tv2 = cyc;
                break;
            end
            tick();
        end
        gap = (tv2 < 0) ? -1 : tv2 - tv;
        check("cont_gap", gap, CONT ? 3 * P + 1 : -1);
        tick(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
